reg_operand_ctrl: RTL

REG_OPERAND_CTRL -- requirements
Module: reg_operand_ctrl

---
 rtl/reg_operand_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_operand_ctrl.sv
// Operand-read decode, destination scoreboard and hazard resolution for an in-order pipe.
// Optional macro REG_FORWARDING_EN enables bypass selection; without it every hazard stalls.
module reg_operand_ctrl #(
   parameter int ADDR_W     = 5,
   parameter int PIPE_DEPTH = 3,
   localparam int SEL_W     = $clog2(PIPE_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic              id_valid,
   input  logic              flush,
   output logic              reg_read_en_1,
   output logic              reg_read_en_2,
   output logic [ADDR_W-1:0] reg_addr_1,
   output logic [ADDR_W-1:0] reg_addr_2,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] reg_write_addr,
   output logic [SEL_W-1:0]  fwd_sel_1,
   output logic [SEL_W-1:0]  fwd_sel_2,
   output logic              stall
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   logic              wr_dec;
   logic [ADDR_W-1:0] wr_addr;
   logic [SEL_W-1:0]  match_1;
   logic [SEL_W-1:0]  match_2;
   logic              stall_raw;

   logic [PIPE_DEPTH:1] vld_q;
   logic [PIPE_DEPTH:1] vld_d;
   logic [PIPE_DEPTH:1] load_q;
   logic [ADDR_W-1:0]   waddr_q [1:PIPE_DEPTH];

   always_comb begin
      reg_read_en_1 = 1'b0;
      reg_read_en_2 = 1'b0;
      reg_addr_1    = '0;
      reg_addr_2    = '0;
      wr_dec        = 1'b0;
      wr_addr       = '0;
      case (op)
         OP_SPECIAL: begin
            reg_read_en_1 = 1'b1; reg_addr_1 = rs;
            reg_read_en_2 = 1'b1; reg_addr_2 = rt;
            wr_dec = 1'b1; wr_addr = rd;
         end
         OP_ADDIU, OP_LW: begin
            reg_read_en_1 = 1'b1; reg_addr_1 = rs;
            wr_dec = 1'b1; wr_addr = rt;
         end
         OP_SW: begin
            reg_read_en_1 = 1'b1; reg_addr_1 = rs;
            reg_read_en_2 = 1'b1; reg_addr_2 = rt;
         end
         OP_LUI: begin
            wr_dec = 1'b1; wr_addr = rt;
         end
         default: ;
      endcase
   end

   assign reg_write_addr = wr_addr;
   assign reg_write_en   = wr_dec && id_valid && (wr_addr != '0);

   // Walk oldest to youngest so the youngest matching stage wins.
   always_comb begin
      match_1 = '0;
      match_2 = '0;
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
         if (reg_read_en_1 && (reg_addr_1 != '0) && vld_q[k] && (waddr_q[k] == reg_addr_1))
            match_1 = SEL_W'(k);
         if (reg_read_en_2 && (reg_addr_2 != '0) && vld_q[k] && (waddr_q[k] == reg_addr_2))
            match_2 = SEL_W'(k);
      end
   end

`ifdef REG_FORWARDING_EN
   assign stall_raw = load_q[1] && ((match_1 == SEL_W'(1)) || (match_2 == SEL_W'(1)));
   assign fwd_sel_1 = rst ? '0 : match_1;
   assign fwd_sel_2 = rst ? '0 : match_2;
`else
   assign stall_raw = (match_1 != '0) || (match_2 != '0);
   assign fwd_sel_1 = '0;
   assign fwd_sel_2 = '0;
`endif

   assign stall = stall_raw && !flush && !rst;

   always_comb begin
      vld_d = '0;
      if (!flush) begin
         for (int k = PIPE_DEPTH; k >= 2; k--)
            vld_d[k] = vld_q[k-1];
         vld_d[1] = reg_write_en && !stall;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   // Payload rides along unreset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      for (int k = PIPE_DEPTH; k >= 2; k--) begin
         waddr_q[k] <= waddr_q[k-1];
         load_q[k]  <= load_q[k-1];
      end
      waddr_q[1] <= reg_write_addr;
      load_q[1]  <= (op == OP_LW);
   end

endmodule
